// File: rtl/prog_mem_loader.sv
// Program memory for the CPU fetch bus, filled from a big-endian byte stream.
// The CPU is held until the load finishes, then fetches see one cycle of read latency.
module prog_mem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       address,
   output logic [DATA_W-1:0] data_out,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_ready,
   input  logic              reload,
   output logic              cpu_run,
   output logic [ADDR_W:0]   load_count,
   output logic              overflow
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {LOAD_HI, LOAD_LO, RUN} state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   wr_ptr_reg;
   logic [7:0]          hi_reg;
   logic [ADDR_W:0]     load_count_reg;
   logic                overflow_reg;
   logic [DATA_W-1:0]   data_reg;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                accept;
   logic                full;
   logic                in_range;
   logic                wr_en;
   logic                set_overflow;
   logic [DATA_W-1:0]   wr_data;

   assign ld_ready   = !rst && (state_reg != RUN);
   assign accept     = ld_valid && ld_ready;
   assign full       = &wr_ptr_reg;
   // load_count never exceeds DEPTH, so this also rejects any high address bit
   assign in_range   = 32'(address) < 32'(load_count_reg);
   assign cpu_run    = (state_reg == RUN);
   assign load_count = load_count_reg;
   assign overflow   = overflow_reg;
   assign data_out   = data_reg;

   always_comb begin
      state_next   = state_reg;
      wr_en        = 1'b0;
      set_overflow = 1'b0;
      wr_data      = {hi_reg, ld_byte};
      case (state_reg)
         LOAD_HI: begin
            if (accept) begin
               if (ld_last) begin
                  wr_en      = 1'b1;
                  wr_data    = {ld_byte, 8'h00};
                  state_next = RUN;
               end else begin
                  state_next = LOAD_LO;
               end
            end
         end
         LOAD_LO: begin
            if (accept) begin
               wr_en = 1'b1;
               if (ld_last || full) begin
                  state_next   = RUN;
                  set_overflow = full && !ld_last;
               end else begin
                  state_next = LOAD_HI;
               end
            end
         end
         RUN: begin
            if (reload) state_next = LOAD_HI;
         end
         default: state_next = LOAD_HI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= LOAD_HI;
         wr_ptr_reg     <= '0;
         load_count_reg <= '0;
         overflow_reg   <= 1'b0;
         hi_reg         <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == LOAD_HI && accept) hi_reg <= ld_byte;
         if (wr_en) begin
            wr_ptr_reg     <= wr_ptr_reg + 1'b1;
            load_count_reg <= (ADDR_W+1)'(wr_ptr_reg) + 1'b1;
         end
         if (set_overflow) overflow_reg <= 1'b1;
         if (state_reg == RUN && reload) begin
            wr_ptr_reg     <= '0;
            load_count_reg <= '0;
            overflow_reg   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_data;
   end

   // Registered read; zero outside RUN, on reload, and beyond the loaded program
   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else if (state_reg == RUN && !reload && in_range) begin
         data_reg <= mem[address[ADDR_W-1:0]];
      end else begin
         data_reg <= '0;
      end
   end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed tables, hand sequences and randomized loads
// checked against a byte-list model of the loaded program.
module tb_prog_mem_loader;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [15:0] address;
   logic [15:0] data_out;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;
   logic        ld_ready;
   logic        reload;
   logic        cpu_run;
   logic [8:0]  load_count;
   logic        overflow;

   logic [15:0] s_address;
   logic [15:0] s_data_out;
   logic        s_ld_valid;
   logic [7:0]  s_ld_byte;
   logic        s_ld_last;
   logic        s_ld_ready;
   logic        s_reload;
   logic        s_cpu_run;
   logic [2:0]  s_load_count;
   logic        s_overflow;

   prog_mem_loader #(.ADDR_W(8), .DATA_W(16)) u_dut (
      .clk(clk), .rst(rst), .address(address), .data_out(data_out),
      .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
      .reload(reload), .cpu_run(cpu_run), .load_count(load_count), .overflow(overflow)
   );

   prog_mem_loader #(.ADDR_W(2), .DATA_W(16)) u_small (
      .clk(clk), .rst(rst), .address(s_address), .data_out(s_data_out),
      .ld_valid(s_ld_valid), .ld_byte(s_ld_byte), .ld_last(s_ld_last), .ld_ready(s_ld_ready),
      .reload(s_reload), .cpu_run(s_cpu_run), .load_count(s_load_count), .overflow(s_overflow)
   );

   typedef struct {
      logic [15:0] addr;
      logic [15:0] exp;
   } rd_vec_t;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  byte_q[$];
   rd_vec_t     vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: the program is the list of accepted bytes, paired big-endian into words
   function automatic int model_count();
      return (byte_q.size() + 1) / 2;
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      logic [7:0] hi, lo;
      int i;
      i = int'(a);
      if (i >= model_count()) return 16'h0000;
      hi = byte_q[2*i];
      lo = (2*i + 1 < byte_q.size()) ? byte_q[2*i+1] : 8'h00;
      return {hi, lo};
   endfunction

   task automatic load_program(input bit gaps);
      int  k = 0;
      int  guard = 0;
      bit  acc;
      while (k < byte_q.size() && guard < 4000) begin
         ld_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ld_byte  = byte_q[k];
         ld_last  = (k == byte_q.size() - 1);
         check("ld_ready_loading", ld_ready, 1);
         check("cpu_run_loading", cpu_run, 0);
         check("data_out_loading", data_out, 0);
         acc = ld_valid && ld_ready;
         tick();
         if (acc) k++;
         guard++;
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      check("load_bytes_accepted", k, byte_q.size());
      check("cpu_run_after_load", cpu_run, 1);
      check("ld_ready_in_run", ld_ready, 0);
      check("load_count", load_count, model_count());
      check("overflow_after_load", overflow, 0);
      $display("load: bytes=%0d words=%0d load_count=%0d", byte_q.size(), model_count(), load_count);
   endtask

   task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
      address = a;
      tick();
      check(name, data_out, exp);
      $display("read: address=%04h data_out=%04h expected=%04h", a, data_out, exp);
      tick();
   endtask

   task automatic reload_pulse();
      reload  = 1'b1;
      address = 16'h0000;
      tick();
      reload = 1'b0;
      check("reload_cpu_run", cpu_run, 0);
      check("reload_load_count", load_count, 0);
      check("reload_data_out", data_out, 0);
      check("reload_ld_ready", ld_ready, 1);
      check("reload_overflow", overflow, 0);
      $display("reload: cpu_run=%0d load_count=%0d", cpu_run, load_count);
   endtask

   initial begin
      rst = 1'b1; address = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0; reload = 1'b0;
      s_address = '0; s_ld_valid = 1'b0; s_ld_byte = '0; s_ld_last = 1'b0; s_reload = 1'b0;

      vecs[0] = '{16'h0000, 16'h8005};
      vecs[1] = '{16'h0001, 16'h8003};
      vecs[2] = '{16'h0002, 16'h0100};
      vecs[3] = '{16'h0003, 16'h0000};
      vecs[4] = '{16'h0100, 16'h0000};
      vecs[5] = '{16'hFFFF, 16'h0000};
      vecs[6] = '{16'h0001, 16'h8003};

      tick();
      tick();
      check("rst_ld_ready_during_rst", ld_ready, 0);
      rst = 1'b0;
      #1;
      check("rst_ld_ready", ld_ready, 1);
      check("rst_cpu_run", cpu_run, 0);
      check("rst_load_count", load_count, 0);
      check("rst_data_out", data_out, 0);
      check("rst_overflow", overflow, 0);
      check("rst_small_ld_ready", s_ld_ready, 1);

      // Basic program and table-driven fetches
      byte_q = '{8'h80, 8'h05, 8'h80, 8'h03, 8'h01, 8'h00};
      load_program(1'b0);
      check("basic_load_count", load_count, 3);
      for (int i = 0; i < 7; i++) read_check("table_read", vecs[i].addr, vecs[i].exp);

      // Program ending on a high byte
      reload_pulse();
      byte_q = '{8'h12, 8'h34, 8'h56};
      load_program(1'b0);
      check("odd_load_count", load_count, 2);
      read_check("odd_read0", 16'h0000, 16'h1234);
      read_check("odd_read1", 16'h0001, 16'h5600);
      read_check("odd_read2", 16'h0002, 16'h0000);

      // Idle gaps between bytes
      reload_pulse();
      byte_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      load_program(1'b1);
      read_check("gap_read0", 16'h0000, 16'hA1B2);
      read_check("gap_read1", 16'h0001, 16'hC3D4);

      // Four-word memory filled without ld_last
      for (int i = 0; i < 10; i++) begin
         s_ld_valid = 1'b1;
         s_ld_byte  = 8'(i * 17 + 1);
         check("small_ld_ready", s_ld_ready, (i < 8) ? 1 : 0);
         tick();
         if (i == 6) check("small_cpu_run_before_full", s_cpu_run, 0);
         if (i == 7) begin
            check("small_cpu_run_full", s_cpu_run, 1);
            check("small_overflow_full", s_overflow, 1);
         end
      end
      s_ld_valid = 1'b0;
      check("small_load_count", s_load_count, 4);
      check("small_overflow_sticky", s_overflow, 1);
      for (int a = 0; a < 6; a++) begin
         logic [15:0] exp;
         s_address = (a == 5) ? 16'h0007 : 16'(a);
         exp = (a < 4) ? {8'(2 * a * 17 + 1), 8'((2 * a + 1) * 17 + 1)} : 16'h0000;
         tick();
         check("small_read", s_data_out, exp);
         $display("read small: address=%04h data_out=%04h expected=%04h", s_address, s_data_out, exp);
         tick();
      end
      s_reload = 1'b1;
      tick();
      s_reload = 1'b0;
      check("small_reload_overflow", s_overflow, 0);
      check("small_reload_cpu_run", s_cpu_run, 0);
      check("small_reload_ld_ready", s_ld_ready, 1);
      check("small_reload_load_count", s_load_count, 0);

      // Reset in the middle of word 1, then reload from RUN
      reload_pulse();
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_byte  = 8'h55 + 8'(i * 17);
         tick();
      end
      ld_valid = 1'b0;
      check("midload_cpu_run", cpu_run, 0);
      rst = 1'b1;
      tick();
      check("midload_rst_ld_ready", ld_ready, 0);
      rst = 1'b0;
      #1;
      check("midload_ld_ready", ld_ready, 1);
      check("midload_load_count", load_count, 0);
      check("midload_cpu_run_after", cpu_run, 0);
      check("midload_data_out", data_out, 0);
      byte_q = '{8'hAB, 8'hCD};
      load_program(1'b0);
      read_check("midload_read0", 16'h0000, 16'hABCD);
      read_check("midload_read1", 16'h0001, 16'h0000);
      reload_pulse();
      byte_q = '{8'h11, 8'h22};
      load_program(1'b0);
      read_check("fresh_read0", 16'h0000, 16'h1122);

      // Randomized loads checked against the byte-list model
      for (int it = 0; it < 8; it++) begin
         int n;
         reload_pulse();
         n = $urandom_range(1, 40);
         byte_q = {};
         for (int j = 0; j < n; j++) byte_q.push_back(8'($urandom()));
         load_program(1'b1);
         for (int r = 0; r < 6; r++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 24)) : 16'($urandom());
            read_check("rand_read", a, model_read(a));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
